// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in, parallel-out receiver, MSB first.
// Assembles WIDTH-bit words from a valid/ready bit stream and presents them
// on a valid/ready word port. The assembly register plus a one-word output
// slot let the next word be collected while the current one waits. The serial
// side is stalled only when both are full.
// Optional feature: define PARITY_CHECK_EN to accept one even-parity bit after
// each word and report a mismatch on PARITY_ERR. Without it PARITY_ERR is 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | shifting data bits in; SER_READY=1
// PARITY  | (PARITY_CHECK_EN only) waiting for the parity bit; SER_READY=1
// FULL    | shreg holds a finished word, output slot occupied; SER_READY=0
module shift_deserializer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SER_IN,
  input  logic             SER_VALID,
  output logic             SER_READY,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_VALID,
  input  logic             DATA_READY,
  output logic             PARITY_ERR
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {COLLECT = 2'd0, FULL = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {COLLECT = 2'd0, FULL = 2'd1} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_q;
  logic             data_valid_q;
  logic             accept;
  logic             drain;
  logic             slot_free;
  logic [WIDTH-1:0] next_word;

  // handshake qualifiers and the word as it looks with the current bit shifted in
  assign accept    = SER_VALID && SER_READY;
  assign drain     = data_valid_q && DATA_READY;
  assign slot_free = !data_valid_q || DATA_READY;
  assign next_word = {shreg[WIDTH-2:0], SER_IN};
  assign SER_READY = (state != FULL);

  assign DATA_OUT   = data_q;
  assign DATA_VALID = data_valid_q;

`ifdef PARITY_CHECK_EN
  logic parity_q;
  logic parity_held;
  logic parity_next;

  // even parity over the stored data bits and the incoming parity bit
  assign parity_next = ^{shreg, SER_IN};
  assign PARITY_ERR  = parity_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  // receive FSM: bit assembly, output slot load and backpressure
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= COLLECT;
      count        <= '0;
      shreg        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_q     <= 1'b0;
      parity_held  <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            shreg <= next_word;
            if (count == LAST) begin
`ifdef PARITY_CHECK_EN
              count <= count + 1'b1;
              state <= PARITY;
              if (drain) data_valid_q <= 1'b0;
`else
              if (slot_free) begin
                // new word replaces any word draining this same cycle
                data_q       <= next_word;
                data_valid_q <= 1'b1;
                count        <= '0;
              end else begin
                count <= count + 1'b1;
                state <= FULL;
              end
`endif
            end else begin
              count <= count + 1'b1;
              if (drain) data_valid_q <= 1'b0;
            end
          end else if (drain) begin
            data_valid_q <= 1'b0;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (accept) begin
            if (slot_free) begin
              data_q       <= shreg;
              parity_q     <= parity_next;
              data_valid_q <= 1'b1;
              count        <= '0;
              state        <= COLLECT;
            end else begin
              parity_held <= parity_next;
              state       <= FULL;
            end
          end else if (drain) begin
            data_valid_q <= 1'b0;
          end
        end
`endif
        FULL: begin
          // slot is occupied here, so DATA_READY alone means the old word leaves
          if (DATA_READY) begin
            data_q <= shreg;
`ifdef PARITY_CHECK_EN
            parity_q <= parity_held;
`endif
            count <= '0;
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed scenarios plus a randomized run
// scored against a queue-based model of words sent vs words consumed.
`timescale 1ns/1ps
module tb_shift_deserializer;
  localparam int WIDTH = 32;
`ifdef PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             SER_IN = 1'b0;
  logic             SER_VALID = 1'b0;
  logic             SER_READY;
  logic [WIDTH-1:0] DATA_OUT;
  logic             DATA_VALID;
  logic             DATA_READY = 1'b0;
  logic             PARITY_ERR;

  shift_deserializer #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .SER_IN(SER_IN), .SER_VALID(SER_VALID),
    .SER_READY(SER_READY), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .PARITY_ERR(PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;
  int unstable = 0;
  logic             last_accept = 1'b0;
  logic [WIDTH-1:0] got_q[$];
  logic             got_perr_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_perr_q[$];

  // one clock: drive inputs, note handshakes before the edge, observe after
  task automatic tick(input logic sv, input logic sb, input logic dr);
    logic acc, take, hold;
    logic [WIDTH-1:0] w;
    logic pe;
    SER_VALID = sv; SER_IN = sb; DATA_READY = dr;
    acc  = sv && SER_READY;
    take = DATA_VALID && dr;
    hold = DATA_VALID && !dr;
    w    = DATA_OUT;
    pe   = PARITY_ERR;
    if (sv && !SER_READY) stalls++;
    @(posedge CLK); #1;
    cyc++;
    if (take) begin
      got_q.push_back(w);
      got_perr_q.push_back(pe);
    end
    if (hold && (DATA_OUT !== w || PARITY_ERR !== pe || DATA_VALID !== 1'b1)) unstable++;
    last_accept = acc;
  endtask

  // send one word MSB first (plus parity bit when enabled), retrying each bit
  // until accepted; gap_pct = chance of an idle serial cycle, dr_pct = chance of DATA_READY
  task automatic send_word(input logic [WIDTH-1:0] word, input logic par,
                           input int gap_pct, input int dr_pct, output int early);
    logic bits[$];
    int tries;
    logic sv, dr;
    early = 0;
    for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(word[i]);
    if (PB != 0) bits.push_back(par);
    exp_q.push_back(word);
    exp_perr_q.push_back((PB != 0) ? ((^word) ^ par) : 1'b0);
    for (int k = 0; k < bits.size(); k++) begin
      tries = 0;
      do begin
        sv = ($urandom_range(99) >= gap_pct);
        dr = ($urandom_range(99) < dr_pct);
        tick(sv, bits[k], dr);
        tries++;
        if (k != bits.size() - 1 && DATA_VALID === 1'b1) early++;
      end while (!last_accept && tries < 400);
      if (!last_accept) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: bit %0d of %h never accepted, expected acceptance", k, word);
        return;
      end
    end
  endtask

  task automatic clear_sb();
    got_q.delete(); got_perr_q.delete(); exp_q.delete(); exp_perr_q.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1; SER_VALID = 1'b0; DATA_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", DATA_VALID); end
    n_checks++; if (DATA_OUT !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", DATA_OUT); end
    n_checks++; if (PARITY_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", PARITY_ERR); end
    #3 RST = 1'b0;
    @(posedge CLK); #1;
    n_checks++; if (SER_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ser_ready: got %b expected 1", SER_READY); end
    n_checks++; if (DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", DATA_VALID); end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] w;
    int early;
    clear_sb(); stalls = 0;
    w = 32'hA5A5_0F0F;
    send_word(w, ^w, 0, 100, early);
    n_checks++; if (DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", DATA_VALID); end
    n_checks++; if (DATA_OUT !== w) begin n_fail++; $display("FAIL single_data: got %h expected %h", DATA_OUT, w); end
    n_checks++; if (PARITY_ERR !== 1'b0) begin n_fail++; $display("FAIL single_perr: got %b expected 0", PARITY_ERR); end
    tick(1'b0, 1'b0, 1'b1);
    n_checks++; if (DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b expected 0", DATA_VALID); end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== w) begin n_fail++; $display("FAIL single_consumed: got %0d words expected 1 of %h", got_q.size(), w); end
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL single_stalls: got %0d expected 0", stalls); end
  endtask

  task automatic test_back_to_back();
    int c1, c2, early;
    clear_sb(); stalls = 0;
    send_word(32'h0000_0001, 1'b1, 0, 100, early);
    c1 = cyc;
    n_checks++; if (DATA_VALID !== 1'b1 || DATA_OUT !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/00000001", DATA_VALID, DATA_OUT); end
    send_word(32'hFFFF_FFFE, 1'b1, 0, 100, early);
    c2 = cyc;
    n_checks++; if (DATA_VALID !== 1'b1 || DATA_OUT !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_second: got %b/%h expected 1/fffffffe", DATA_VALID, DATA_OUT); end
    n_checks++; if (c2 - c1 != WIDTH + PB) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", c2 - c1, WIDTH + PB); end
    tick(1'b0, 1'b0, 1'b1);
    n_checks++; if (got_q.size() != 2 || got_q[0] !== 32'h0000_0001 || got_q[1] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_consumed: got %0d words expected 2", got_q.size()); end
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
  endtask

  task automatic test_backpressure();
    int early;
    clear_sb(); unstable = 0;
    send_word(32'h0000_0001, 1'b1, 0, 0, early);
    send_word(32'hFFFF_FFFE, 1'b1, 0, 0, early);
    n_checks++; if (SER_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ser_ready: got %b expected 0", SER_READY); end
    n_checks++; if (DATA_VALID !== 1'b1 || DATA_OUT !== 32'h0000_0001) begin n_fail++; $display("FAIL bp_held: got %b/%h expected 1/00000001", DATA_VALID, DATA_OUT); end
    stalls = 0;
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    n_checks++; if (stalls != 3 || DATA_OUT !== 32'h0000_0001) begin n_fail++; $display("FAIL bp_stall: got %0d stalls data %h expected 3 / 00000001", stalls, DATA_OUT); end
    tick(1'b0, 1'b0, 1'b1);
    n_checks++; if (DATA_OUT !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL bp_promote_data: got %h expected fffffffe", DATA_OUT); end
    n_checks++; if (DATA_VALID !== 1'b1 || SER_READY !== 1'b1) begin n_fail++; $display("FAIL bp_promote_flags: got valid %b ready %b expected 1 1", DATA_VALID, SER_READY); end
    tick(1'b0, 1'b0, 1'b1);
    n_checks++; if (DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", DATA_VALID); end
    n_checks++; if (got_q.size() != 2 || got_q[0] !== 32'h0000_0001 || got_q[1] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL bp_order: got %0d words expected 2", got_q.size()); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
  endtask

  task automatic test_gaps();
    int early;
    clear_sb();
    send_word(32'hDEAD_BEEF, ^(32'hDEAD_BEEF), 50, 100, early);
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL gaps_early_valid: got %0d cycles expected 0", early); end
    n_checks++; if (DATA_VALID !== 1'b1 || DATA_OUT !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL gaps_word: got %b/%h expected 1/deadbeef", DATA_VALID, DATA_OUT); end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int early;
    clear_sb();
    repeat (10) tick(1'b1, 1'b1, 1'b1);
    #2 RST = 1'b1;
    #1;
    n_checks++; if (DATA_VALID !== 1'b0 || DATA_OUT !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %b/%h expected 0/0", DATA_VALID, DATA_OUT); end
    @(posedge CLK); #1;
    RST = 1'b0;
    send_word(32'h1234_5678, ^(32'h1234_5678), 0, 100, early);
    n_checks++; if (DATA_VALID !== 1'b1 || DATA_OUT !== 32'h1234_5678) begin n_fail++; $display("FAIL midreset_word: got %b/%h expected 1/12345678", DATA_VALID, DATA_OUT); end
    tick(1'b0, 1'b0, 1'b1);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    int early;
    clear_sb();
    send_word(32'h0000_0001, 1'b1, 0, 100, early);
    n_checks++; if (PARITY_ERR !== 1'b0 || DATA_OUT !== 32'h0000_0001) begin n_fail++; $display("FAIL parity_good: got %b/%h expected 0/00000001", PARITY_ERR, DATA_OUT); end
    send_word(32'h0000_0001, 1'b0, 0, 100, early);
    n_checks++; if (PARITY_ERR !== 1'b1 || DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL parity_bad: got %b/%b expected 1/1", PARITY_ERR, DATA_VALID); end
    tick(1'b0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_random();
    int early, budget;
    logic [WIDTH-1:0] w;
    logic par;
    clear_sb(); unstable = 0;
    for (int n = 0; n < 20; n++) begin
      w   = $urandom;
      par = 1'($urandom_range(1));
      send_word(w, par, 30, 60, early);
    end
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 200) begin
      tick(1'b0, 1'b0, 1'b1);
      budget++;
    end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      n_checks++; if (got_perr_q[i] !== exp_perr_q[i]) begin n_fail++; $display("FAIL rand_perr[%0d]: got %b expected %b", i, got_perr_q[i], exp_perr_q[i]); end
    end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL rand_stable: got %0d changes expected 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_reset_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
